module_keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner that drives one column low at a time, senses active-low row lines, debounces press and release, and reports the pressed key as a binary code. A row bus of all ones means no key is pressed, which extends the single-column key-present check into full scanning. Sits between the keypad pins and the key-consuming logic (code entry, display); it provides one `key_valid` pulse per debounced press.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/module_sync_2ff.sv | 41 ++++
 rtl/module_keypad_scanner.sv | 193 +++++++++++++++++++
 tb/tb_module_keypad_scanner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the matrix keypad scanner: the controller state
// encoding and the width helpers used to size the key code and counters.
// No ports; imported by module_keypad_scanner.
package keypad_pkg;

  // Controller states: scanning columns, qualifying a press, holding an
  // accepted key, and qualifying its release.
  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_t;

  // Width of a key code that numbers every key as row*cols + col.
  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Width of a counter or index that must hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/module_sync_2ff.sv
// module_sync_2ff
// Two-flop synchroniser for a bus of asynchronous, active-low lines. The
// flops reset to all ones so the idle (released) level is seen during reset.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   d_i  - asynchronous input bus
//   q_o  - synchronised output bus, two clocks behind d_i
module module_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1_d, stage1_q;
  logic [WIDTH-1:0] stage2_d, stage2_q;

  // The first stage takes the raw pins; the second stage gives the first
  // stage a full clock period to settle before anything downstream sees it.
  always_comb begin
    stage1_d = d_i;
    stage2_d = stage1_q;
  end

  // Both stages return to the released level on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '1;
      stage2_q <= '1;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/module_keypad_scanner.sv
// module_keypad_scanner
// Scans a ROWS x COLS matrix keypad by driving one column low at a time and
// sensing active-low rows. A detected key is debounced on press and release;
// an accepted press yields a one-cycle key_valid_o pulse with its code.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   rows_i      - raw active-low row lines, asynchronous to clk
//   cols_o      - active-low column drive, exactly one bit low
//   key_code_o  - code of the last accepted key, row*COLS + col
//   key_valid_o - one-cycle pulse when a press is accepted
//   key_held_o  - high from press acceptance until release acceptance
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS            = 4,
  parameter  int COLS            = 4,
  parameter  int SCAN_DIV        = 4,
  parameter  int DEBOUNCE_CYCLES = 8,
  localparam int CODE_W          = code_width(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   rows_i,
  output logic [COLS-1:0]   cols_o,
  output logic [CODE_W-1:0] key_code_o,
  output logic              key_valid_o,
  output logic              key_held_o
);

  localparam int SCAN_W = cnt_width(SCAN_DIV);
  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int ROW_W  = cnt_width(ROWS);
  localparam int COL_W  = cnt_width(COLS);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

  logic [ROWS-1:0] rows_s;

  kp_state_t         state_d, state_q;
  logic [SCAN_W-1:0] scan_cnt_d, scan_cnt_q;
  logic [DB_W-1:0]   db_cnt_d, db_cnt_q;
  logic [COL_W-1:0]  col_idx_d, col_idx_q;
  logic [ROW_W-1:0]  row_lat_d, row_lat_q;
  logic [COLS-1:0]   cols_d, cols_q;
  logic [CODE_W-1:0] key_code_d, key_code_q;
  logic              key_valid_d, key_valid_q;
  logic              key_held_d, key_held_q;

  logic              tick;
  logic              any_low;
  logic [ROW_W-1:0]  low_row;
  logic              lat_high;
  logic [COL_W-1:0]  col_next;

  // Bring the asynchronous row pins into the clock domain before any
  // decision is made on them.
  module_sync_2ff #(
    .WIDTH (ROWS)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rows_i),
    .q_o (rows_s)
  );

  // Find the lowest-numbered row that is pulled low; scanning downwards
  // lets the lowest index overwrite any higher one when several are low.
  always_comb begin
    any_low = ~&rows_s;
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rows_s[r]) begin
        low_row = ROW_W'(r);
      end
    end
  end

  // Helpers shared by the state machine: end of a column period, level of
  // the latched row, and the wrapped next column.
  always_comb begin
    tick     = (scan_cnt_q == SCAN_LAST);
    lat_high = rows_s[row_lat_q];
    col_next = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
  end

  // Next-state and output logic. The column index only moves in SCAN
  // (when idle) or on an accepted release, so the key's column stays driven
  // from detection until release. The scan counter is cleared on every exit
  // to SCAN so a column always gets a full period after being re-entered.
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    col_idx_d   = col_idx_q;
    row_lat_d   = row_lat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      SCAN: begin
        if (tick) begin
          scan_cnt_d = '0;
          if (any_low) begin
            row_lat_d = low_row;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_next;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (lat_high) begin
          scan_cnt_d = '0;
          state_d    = SCAN;
        end else if (db_cnt_q == DB_LAST) begin
          key_code_d  = CODE_W'(row_lat_q) * CODE_W'(COLS) + CODE_W'(col_idx_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = PRESSED;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (lat_high) begin
          db_cnt_d = '0;
          state_d  = RELEASE;
        end
      end

      RELEASE: begin
        if (!lat_high) begin
          db_cnt_d = '0;
          state_d  = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          key_held_d = 1'b0;
          col_idx_d  = col_next;
          scan_cnt_d = '0;
          state_d    = SCAN;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    cols_d = ~(COLS'(1) << col_idx_d);
  end

  // State and output registers. Every output comes straight from a flop,
  // and reset returns everything to column 0 with no key held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      col_idx_q   <= '0;
      row_lat_q   <= '0;
      cols_q      <= ~COLS'(1);
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      col_idx_q   <= col_idx_d;
      row_lat_q   <= row_lat_d;
      cols_q      <= cols_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign cols_o      = cols_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// tb_module_keypad_scanner
// Directed bench for the keypad scanner. Expected key events (code plus the
// cycle on which the pulse must appear) are queued by the stimulus; a
// monitor pops one entry per key_valid_o pulse. Level checks on cols_o and
// key_held_o are made at fixed points of each scenario.
module tb_module_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] rows_i;
  logic [3:0] cols_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_held_o;

  typedef struct {
    logic [3:0] code;
    int         cycle;
  } exp_t;

  exp_t sbQueue[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   cycleCount  = 0;

  module_keypad_scanner #(
    .ROWS            (4),
    .COLS            (4),
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rows_i      (rows_i),
    .cols_o      (cols_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o),
    .key_held_o  (key_held_o)
  );

  // Free-running clock; inputs change and outputs are sampled on the
  // falling edge, away from the rising edge the design uses.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge count, used to timestamp expected key pulses.
  always @(posedge clk) cycleCount++;

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cycleCount);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rows);
    rows_i = rows;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExpect(input logic [3:0] code, input int cycle);
    exp_t e;
    e.code  = code;
    e.cycle = cycle;
    sbQueue.push_back(e);
  endtask

  // Step falling edges until the given column has just become driven
  // (first cycle of that column), bounded to a few scan rounds.
  task automatic waitColumn(input logic [3:0] target);
    logic [3:0] prev;
    logic       found;
    prev  = cols_o;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (cols_o == target && prev != target) found = 1'b1;
      prev = cols_o;
    end
    checkOutput("wait_column_found", {31'd0, found}, 32'd1);
  endtask

  // Monitor: every key_valid_o pulse must match the oldest queued press,
  // both in code and in the cycle on which it appears.
  always @(negedge clk) begin
    if (key_valid_o === 1'b1) begin
      if (sbQueue.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_pulse: code %0d at cycle %0d, expected no pulse",
                 key_code_o, cycleCount);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("pulse_code", {28'd0, key_code_o}, {28'd0, e.code});
        checkOutput("pulse_cycle", cycleCount, e.cycle);
      end
    end
  end

  initial begin
    logic [3:0] idlePattern [4];
    idlePattern[0] = 4'b1110;
    idlePattern[1] = 4'b1101;
    idlePattern[2] = 4'b1011;
    idlePattern[3] = 4'b0111;

    rst = 1'b1;
    applyStimulus(4'b1111);

    // Reset held for three rising edges.
    waitCycles(3);
    $display("[TB] reset state");
    checkOutput("reset_cols", {28'd0, cols_o}, 32'hE);
    checkOutput("reset_code", {28'd0, key_code_o}, 32'd0);
    checkOutput("reset_valid", {31'd0, key_valid_o}, 32'd0);
    checkOutput("reset_held", {31'd0, key_held_o}, 32'd0);
    rst = 1'b0;

    // Idle scan: each column for four cycles, wrapping back to column 0.
    $display("[TB] idle scan");
    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clk);
      checkOutput("idle_cols", {28'd0, cols_o}, {28'd0, idlePattern[(i / 4) % 4]});
    end

    // Clean press of row 2 on column 1 -> code 9.
    $display("[TB] clean press");
    waitColumn(4'b1101);
    applyStimulus(4'b1011);
    pushExpect(4'd9, cycleCount + 12);
    waitCycles(11);
    checkOutput("press_held_early", {31'd0, key_held_o}, 32'd0);
    waitCycles(1);
    checkOutput("press_held_set", {31'd0, key_held_o}, 32'd1);
    waitCycles(8);
    applyStimulus(4'b1111);
    waitCycles(10);
    checkOutput("release_held_late", {31'd0, key_held_o}, 32'd1);
    checkOutput("release_cols_hold", {28'd0, cols_o}, 32'hD);
    waitCycles(1);
    checkOutput("release_held_clr", {31'd0, key_held_o}, 32'd0);
    checkOutput("release_next_col", {28'd0, cols_o}, 32'hB);
    checkOutput("code_persists", {28'd0, key_code_o}, 32'd9);

    // Bounce: row 0 low for three cycles on column 3 -> no pulse, and the
    // column period restarts once the debounce is abandoned.
    $display("[TB] press bounce");
    waitColumn(4'b0111);
    applyStimulus(4'b1110);
    waitCycles(3);
    applyStimulus(4'b1111);
    waitCycles(6);
    checkOutput("bounce_cols_hold", {28'd0, cols_o}, 32'h7);
    waitCycles(1);
    checkOutput("bounce_cols_next", {28'd0, cols_o}, 32'hE);
    checkOutput("bounce_held", {31'd0, key_held_o}, 32'd0);

    // Release bounce: row 3 on column 2 (code 14), a four-cycle release
    // glitch must not drop key_held_o or produce a second pulse.
    $display("[TB] release bounce");
    waitColumn(4'b1011);
    applyStimulus(4'b0111);
    pushExpect(4'd14, cycleCount + 12);
    waitCycles(20);
    applyStimulus(4'b1111);
    waitCycles(4);
    applyStimulus(4'b0111);
    waitCycles(2);
    checkOutput("rbounce_held_a", {31'd0, key_held_o}, 32'd1);
    waitCycles(4);
    checkOutput("rbounce_held_b", {31'd0, key_held_o}, 32'd1);
    checkOutput("rbounce_cols", {28'd0, cols_o}, 32'hB);
    waitCycles(2);
    applyStimulus(4'b1111);
    waitCycles(10);
    checkOutput("rbounce_held_late", {31'd0, key_held_o}, 32'd1);
    waitCycles(1);
    checkOutput("rbounce_held_clr", {31'd0, key_held_o}, 32'd0);
    checkOutput("rbounce_next_col", {28'd0, cols_o}, 32'h7);
    checkOutput("rbounce_code", {28'd0, key_code_o}, 32'd14);

    // Multi-key: rows 1 and 3 on column 0, lowest row wins -> code 4.
    // Then reset while PRESSED.
    $display("[TB] multi-key and reset");
    waitColumn(4'b1110);
    applyStimulus(4'b0101);
    pushExpect(4'd4, cycleCount + 12);
    waitCycles(12);
    checkOutput("multi_held", {31'd0, key_held_o}, 32'd1);
    checkOutput("multi_code", {28'd0, key_code_o}, 32'd4);
    waitCycles(2);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("mreset_cols", {28'd0, cols_o}, 32'hE);
    checkOutput("mreset_code", {28'd0, key_code_o}, 32'd0);
    checkOutput("mreset_valid", {31'd0, key_valid_o}, 32'd0);
    checkOutput("mreset_held", {31'd0, key_held_o}, 32'd0);
    applyStimulus(4'b1111);
    rst = 1'b0;
    waitCycles(20);
    checkOutput("post_reset_held", {31'd0, key_held_o}, 32'd0);

    checkOutput("scoreboard_drained", sbQueue.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
